// File: rtl/clock_pkg.sv
// Shared definitions for the clock/alarm set-mode front end:
// mode encodings, time-field bit positions and small mode helpers.
package clock_pkg;

  localparam int MODE_W = 3;

  localparam int F_CMIN = 0;
  localparam int F_CHR  = 1;
  localparam int F_AMIN = 2;
  localparam int F_AHR  = 3;

  typedef enum logic [MODE_W-1:0] {
    RUN    = 3'd0,
    SET_CH = 3'd1,
    SET_CM = 3'd2,
    SET_AH = 3'd3,
    SET_AM = 3'd4
  } mode_e;

  function automatic logic is_set(input mode_e m);
    return (m == SET_CH) || (m == SET_CM) || (m == SET_AH) || (m == SET_AM);
  endfunction

  function automatic logic is_legal(input mode_e m);
    return (m == RUN) || is_set(m);
  endfunction

  function automatic mode_e advance(input mode_e m);
    mode_e n;
    case (m)
      RUN:     n = SET_CH;
      SET_CH:  n = SET_CM;
      SET_CM:  n = SET_AH;
      SET_AH:  n = SET_AM;
      default: n = RUN;
    endcase
    return n;
  endfunction

  // One-hot pulse lane for the field being adjusted; zero outside set modes.
  function automatic logic [3:0] field_mask(input mode_e m);
    logic [3:0] mask;
    mask = 4'b0000;
    case (m)
      SET_CH:  mask[F_CHR]  = 1'b1;
      SET_CM:  mask[F_CMIN] = 1'b1;
      SET_AH:  mask[F_AHR]  = 1'b1;
      SET_AM:  mask[F_AMIN] = 1'b1;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/button_repeater.sv
// Edge detector plus hold/rate counters for one adjust button. o_fire is a
// combinational one-cycle request; the parent registers and routes it.
module button_repeater
  import clock_pkg::*;
#(
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int CW           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_btn,
  input  logic i_clear,
  output logic o_fire
);

  logic          r_prev;
  logic          r_armed;
  logic [CW-1:0] r_hold;
  logic [CW-1:0] r_rate;

  logic w_edge;
  logic w_active;
  logic w_hold_hit;
  logic w_rate_hit;

  // A button disarmed by a clear stays silent until it is released and pressed again.
  assign w_edge     = i_btn & ~r_prev & ~i_clear;
  assign w_active   = i_btn & r_armed & ~i_clear;
  assign w_hold_hit = w_active & i_tick & (r_hold == CW'(REPEAT_DELAY - 1));
  assign w_rate_hit = w_active & i_tick & (r_hold == CW'(REPEAT_DELAY))
                    & (r_rate == CW'(REPEAT_RATE - 1));
  assign o_fire     = w_edge | w_hold_hit | w_rate_hit;

  // Edge history, arm flag and hold/rate counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_hold  <= '0;
      r_rate  <= '0;
    end else begin
      r_prev  <= i_btn;
      r_armed <= w_edge | w_active;
      if (!w_active) begin
        r_hold <= '0;
        r_rate <= '0;
      end else if (i_tick) begin
        if (r_hold != CW'(REPEAT_DELAY)) begin
          r_hold <= r_hold + CW'(1);
        end else if (w_rate_hit) begin
          r_rate <= '0;
        end else begin
          r_rate <= r_rate + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/time_adjust_controller.sv
// Set-mode FSM and adjust-pulse generator feeding the clock/alarm counters:
// routes up/down presses to one time field, blinks it, and times out to RUN.
module time_adjust_controller
  import clock_pkg::*;
#(
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int TIMEOUT      = 10000,
  parameter int BLINK_HALF   = 250,
  parameter int CW           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              btn_mode,
  input  logic              btn_up,
  input  logic              btn_down,
  output logic [3:0]        up_pulse,
  output logic [3:0]        down_pulse,
  output logic              clock_run,
  output logic [MODE_W-1:0] mode,
  output logic              blink
);

  mode_e         r_mode;
  mode_e         w_next_mode;
  logic          r_mode_prev;
  logic [CW-1:0] r_to;
  logic [CW-1:0] r_blink_cnt;
  logic          r_blink;
  logic          r_run;
  logic [3:0]    r_up;
  logic [3:0]    r_down;

  logic       w_mode_edge;
  logic       w_in_set;
  logic       w_any_btn;
  logic       w_to_hit;
  logic       w_mode_chg;
  logic       w_clear;
  logic       w_up_fire;
  logic       w_down_fire;
  logic [3:0] w_mask;

  assign w_mode_edge = btn_mode & ~r_mode_prev;
  assign w_in_set    = is_set(r_mode);
  assign w_any_btn   = btn_mode | btn_up | btn_down;
  assign w_to_hit    = w_in_set & tick & ~w_any_btn & (r_to == CW'(TIMEOUT - 1));
  assign w_mode_chg  = (w_next_mode != r_mode);
  // Chords, mode changes and RUN all disarm the repeaters.
  assign w_clear     = w_mode_chg | (btn_up & btn_down) | ~w_in_set;
  assign w_mask      = field_mask(r_mode);

  button_repeater #(
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .CW(CW)
  ) u_rep_up (
    .clk(clk), .rst(rst), .i_tick(tick), .i_btn(btn_up),
    .i_clear(w_clear), .o_fire(w_up_fire)
  );

  button_repeater #(
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .CW(CW)
  ) u_rep_down (
    .clk(clk), .rst(rst), .i_tick(tick), .i_btn(btn_down),
    .i_clear(w_clear), .o_fire(w_down_fire)
  );

  // Next mode: a mode press outranks an expiring timeout.
  always_comb begin
    w_next_mode = r_mode;
    if (!is_legal(r_mode)) begin
      w_next_mode = RUN;
    end else if (w_mode_edge) begin
      w_next_mode = advance(r_mode);
    end else if (w_to_hit) begin
      w_next_mode = RUN;
    end else begin
      w_next_mode = r_mode;
    end
  end

  // Mode register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mode      <= RUN;
      r_mode_prev <= 1'b0;
      r_run       <= 1'b0;
      r_up        <= 4'b0000;
      r_down      <= 4'b0000;
    end else begin
      r_mode      <= w_next_mode;
      r_mode_prev <= btn_mode;
      r_run       <= (w_next_mode == RUN);
      r_up        <= w_up_fire ? w_mask : 4'b0000;
      r_down      <= (w_down_fire & ~w_up_fire) ? w_mask : 4'b0000;
    end
  end

  // Inactivity counter, saturating at TIMEOUT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_to <= '0;
    end else if (!w_in_set || w_mode_chg || w_any_btn) begin
      r_to <= '0;
    end else if (tick && (r_to != CW'(TIMEOUT))) begin
      r_to <= r_to + CW'(1);
    end
  end

  // Blink phase restarts lit on every entry into a set mode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_blink     <= 1'b0;
      r_blink_cnt <= '0;
    end else if (w_next_mode == RUN) begin
      r_blink     <= 1'b0;
      r_blink_cnt <= '0;
    end else if (w_mode_chg) begin
      r_blink     <= 1'b1;
      r_blink_cnt <= '0;
    end else if (tick) begin
      if (r_blink_cnt == CW'(BLINK_HALF - 1)) begin
        r_blink     <= ~r_blink;
        r_blink_cnt <= '0;
      end else begin
        r_blink_cnt <= r_blink_cnt + CW'(1);
      end
    end
  end

  assign up_pulse   = r_up;
  assign down_pulse = r_down;
  assign clock_run  = r_run;
  assign mode       = r_mode;
  assign blink      = r_blink;

endmodule

// File: tb/tb_time_adjust_controller.sv
// Directed bench for time_adjust_controller: a vector table for the basic
// set-mode flow plus hand-written sequences for repeat, chord, timeout, reset.
module tb_time_adjust_controller;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [3:0] up_pulse;
  logic [3:0] down_pulse;
  logic       clock_run;
  logic [2:0] mode;
  logic       blink;

  int n_checks;
  int n_fail;

  time_adjust_controller #(
    .REPEAT_DELAY(4), .REPEAT_RATE(2), .TIMEOUT(20), .BLINK_HALF(3), .CW(16)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .up_pulse(up_pulse), .down_pulse(down_pulse),
    .clock_run(clock_run), .mode(mode), .blink(blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       bm;
    logic       bu;
    logic       bd;
    logic [3:0] eu;
    logic [3:0] ed;
    logic [2:0] em;
    logic       er;
    logic       eb;
    logic       cb;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic bm, input logic bu, input logic bd,
                              input logic [3:0] eu, input logic [3:0] ed,
                              input logic [2:0] em, input logic er,
                              input logic eb, input logic cb);
    vec_t v;
    v.bm = bm; v.bu = bu; v.bd = bd;
    v.eu = eu; v.ed = ed; v.em = em; v.er = er; v.eb = eb; v.cb = cb;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic bm, input logic bu, input logic bd);
    btn_mode = bm;
    btn_up   = bu;
    btn_down = bd;
  endtask

  task automatic mode_press(input logic [2:0] em);
    drive(1'b1, 1'b0, 1'b0);
    cyc();
    chk("mode_press", {29'd0, mode}, {29'd0, em});
    drive(1'b0, 1'b0, 1'b0);
    cyc();
  endtask

  initial begin
    int npulse;
    n_checks = 0;
    n_fail   = 0;
    tick     = 1'b1;
    rst      = 1'b0;
    drive(1'b0, 1'b0, 1'b0);

    // reset held for three cycles
    for (int i = 0; i < 3; i++) cyc();
    chk("rst_up",    {28'd0, up_pulse},   32'd0);
    chk("rst_down",  {28'd0, down_pulse}, 32'd0);
    chk("rst_run",   {31'd0, clock_run},  32'd0);
    chk("rst_mode",  {29'd0, mode},       32'd0);
    chk("rst_blink", {31'd0, blink},      32'd0);
    rst = 1'b1;
    cyc();
    chk("post_rst_mode", {29'd0, mode},      32'd0);
    chk("post_rst_run",  {31'd0, clock_run}, 32'd1);

    // table: enter SET_CH, single up press, blink phase
    add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd1, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd1, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'b0010, 4'b0000, 3'd1, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].bm, tbl[i].bu, tbl[i].bd);
      cyc();
      chk("tbl_up",   {28'd0, up_pulse},   {28'd0, tbl[i].eu});
      chk("tbl_down", {28'd0, down_pulse}, {28'd0, tbl[i].ed});
      chk("tbl_mode", {29'd0, mode},       {29'd0, tbl[i].em});
      chk("tbl_run",  {31'd0, clock_run},  {31'd0, tbl[i].er});
      if (tbl[i].cb) chk("tbl_blink", {31'd0, blink}, {31'd0, tbl[i].eb});
    end

    // chord for 10 cycles, then keep only down held: still silent
    drive(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("chord_pulses", {24'd0, up_pulse, down_pulse}, 32'd0);
    end
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("chord_release", {24'd0, up_pulse, down_pulse}, 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0);
    cyc();

    // advance to SET_AM and hold down for 12 cycles
    mode_press(3'd2);
    mode_press(3'd3);
    mode_press(3'd4);
    npulse = 0;
    drive(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (down_pulse != 4'b0000) npulse++;
      chk("rep_down",
          {28'd0, down_pulse},
          ((k == 0) || (k == 4) || (k == 6) || (k == 8) || (k == 10)) ? 32'd4 : 32'd0);
      chk("rep_up", {28'd0, up_pulse}, 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (down_pulse != 4'b0000) npulse++;
    end
    chk("rep_count", npulse, 32'd5);

    // back to RUN; buttons ignored there
    drive(1'b1, 1'b0, 1'b0);
    cyc();
    chk("run_mode",  {29'd0, mode},      32'd0);
    chk("run_run",   {31'd0, clock_run}, 32'd1);
    chk("run_blink", {31'd0, blink},     32'd0);
    drive(1'b0, 1'b1, 1'b0);
    cyc();
    chk("run_ignore", {24'd0, up_pulse, down_pulse}, 32'd0);
    cyc();
    chk("run_ignore2", {24'd0, up_pulse, down_pulse}, 32'd0);
    drive(1'b0, 1'b0, 1'b0);
    cyc();

    // inactivity timeout from SET_CM
    mode_press(3'd1);
    drive(1'b1, 1'b0, 1'b0);
    cyc();
    chk("to_enter", {29'd0, mode}, 32'd2);
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("to_mode", {29'd0, mode}, (i < 19) ? 32'd2 : 32'd0);
    end
    chk("to_run", {31'd0, clock_run}, 32'd1);

    // mode press in the timeout cycle wins
    mode_press(3'd1);
    drive(1'b1, 1'b0, 1'b0);
    cyc();
    chk("race_enter", {29'd0, mode}, 32'd2);
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) cyc();
    chk("race_pre", {29'd0, mode}, 32'd2);
    drive(1'b1, 1'b0, 1'b0);
    cyc();
    chk("race_mode", {29'd0, mode}, 32'd3);
    drive(1'b0, 1'b0, 1'b0);
    cyc();

    // reset in the middle of an up auto-repeat in SET_AH
    drive(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("ah_rep", {28'd0, up_pulse}, ((k == 0) || (k == 4)) ? 32'd8 : 32'd0);
    end
    rst = 1'b0;
    cyc();
    chk("mid_rst_up",   {28'd0, up_pulse},  32'd0);
    chk("mid_rst_mode", {29'd0, mode},      32'd0);
    chk("mid_rst_run",  {31'd0, clock_run}, 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("after_rst_up", {24'd0, up_pulse, down_pulse}, 32'd0);
      chk("after_rst_mode", {29'd0, mode}, 32'd0);
    end
    chk("after_rst_run", {31'd0, clock_run}, 32'd1);
    drive(1'b0, 1'b0, 1'b0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_adjust_controller.md
Name: time_adjust_controller

Overview:
- Front-end controller that drives the count_up/count_down/en side of the clock and alarm modulo counters.
- Turns debounced push-button levels into single-cycle adjust pulses, routed to one of four time fields. Held buttons auto-repeat.
- Sequences the set-mode FSM, gates the running clock while setting, and returns to run mode on inactivity timeout.

Parameters:
- REPEAT_DELAY, 500, tick strobes a button must be held before auto-repeat starts
- REPEAT_RATE, 100, tick strobes between auto-repeat pulses
- TIMEOUT, 10000, tick strobes with no button activity before a set state returns to RUN
- BLINK_HALF, 250, tick strobes per half-period of the blink output
- CW, 16, width of the internal tick counters; must hold max(REPEAT_DELAY, TIMEOUT)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- tick  in  1  one-cycle time-base strobe; all delays are counted in ticks
- btn_mode  in  1  debounced level; advances the set mode
- btn_up  in  1  debounced level; increment
- btn_down  in  1  debounced level; decrement
- up_pulse  out  4  one-cycle increment strobes; bits: [0] clock min, [1] clock hr, [2] alarm min, [3] alarm hr
- down_pulse  out  4  one-cycle decrement strobes; same bit order
- clock_run  out  1  enable to the seconds counter chain
- mode  out  3  current FSM state encoding
- blink  out  1  display blink for the field being set

Behaviour:
- Reset: synchronous, active-low. Interface is one clock (clk); reset is rst, synchronous, active-low.
- Reset values: mode=RUN(0), up_pulse=0, down_pulse=0, clock_run=0, blink=0. All counters and edge-history registers are 0.
- All outputs are registered. clock_run is 1 from the first cycle after reset release while mode is RUN.
- FSM states: RUN=0, SET_CH=1, SET_CM=2, SET_AH=3, SET_AM=4. Encodings 5-7 are illegal and go to RUN on the next cycle.
- A btn_mode rising edge (registered previous-level compare) advances RUN->SET_CH->SET_CM->SET_AH->SET_AM->RUN. The new mode is visible one cycle after the edge sample.
- clock_run=1 only in RUN. It deasserts in the cycle the mode output leaves RUN.
- Field routing: SET_CH -> bit1, SET_CM -> bit0, SET_AH -> bit3, SET_AM -> bit2. In RUN, btn_up and btn_down are ignored and no pulses are produced.
- Single press: a btn_up rising edge in a set state gives up_pulse[field]=1 for exactly one cycle, in the cycle after the edge sample. btn_down behaves the same on down_pulse.
- Auto-repeat:
  - While the button stays high, a hold counter increments on each tick.
  - When it reaches REPEAT_DELAY, one pulse is issued and a rate counter starts.
  - Thereafter one pulse is issued every REPEAT_RATE ticks.
  - Release clears both counters.
- Both btn_up and btn_down high: no pulses, both repeat counters held at 0. Releasing one does not create a new edge for the other; the remaining button waits for a fresh rising edge.
- Mode change while a button is held: repeat counters clear, and no further pulses occur until a new rising edge.
- At most one bit of up_pulse|down_pulse is set in any cycle.
- Inactivity timeout:
  - In set states, a counter increments on tick and clears on any button rising edge or on any button being held.
  - Reaching TIMEOUT forces RUN.
  - If btn_mode edge and timeout occur in the same cycle, the btn_mode edge wins.
- blink: in set states it toggles every BLINK_HALF ticks, starting at 1 on set-mode entry. It is 0 in RUN.
- Counter saturation: counters never wrap; they stop at their terminal value.
- Reset mid-repeat: outputs return to reset values in the next cycle, with no residual pulse.

Decomposition:
- Shared package (clock_pkg): state encodings RUN..SET_AM, field bit indices F_CMIN=0, F_CHR=1, F_AMIN=2, F_AHR=3, and the mode width constant.
- Sub-module button_repeater: edge detect plus hold/rate counters, producing a one-cycle press_pulse. Instantiated twice (up and down), with a clear input driven on mode change or on both buttons being pressed.

Test Plan:
(Bench parameters: tick tied high, REPEAT_DELAY=4, REPEAT_RATE=2, TIMEOUT=20, BLINK_HALF=3.)
- rst low for 3 cycles, then high -> all outputs 0 during reset; from the next cycle mode=0 and clock_run=1.
- btn_mode pulse -> mode=1, clock_run=0; then btn_up held 1 cycle -> up_pulse=4'b0010 for exactly one cycle, 1 cycle after the edge.
- In SET_AM, btn_down held 12 cycles -> down_pulse=4'b0100 at the press, then at hold count 4, then every 2 ticks: 5 pulses total; none after release.
- btn_up and btn_down asserted together for 10 cycles in SET_CH -> zero pulses.
- Enter SET_CM and stay idle for 20 ticks -> mode returns to 0 and clock_run=1; a btn_mode edge in the same cycle as timeout instead moves to SET_AH.
- rst asserted mid auto-repeat in SET_AH -> next cycle pulses=0 and mode=0; after release, btn_up still held gives no pulse.
